// File: rtl/vip_osd_pkg.sv
// Shared constants for the OSD overlay: pipeline depth, alpha width,
// blend shift and the bitmap bit-order convention.
package vip_osd_pkg;

   localparam int OSD_LATENCY   = 3;
   localparam int ALPHA_BITS    = 8;
   localparam int BLEND_SHIFT   = 8;
   localparam bit BIT_MSB_FIRST = 1'b1;

   // Word bit that holds the pixel at offset p_low within the word.
   function automatic int unsigned bit_sel(input int unsigned p_low, input int unsigned word_bits);
      return BIT_MSB_FIRST ? (word_bits - 1 - p_low) : p_low;
   endfunction

endpackage

// File: rtl/vip_osd_ram.sv
// Simple dual-port bitmap RAM: port A config read/write, port B video read.
// Same-address A write / B read in one cycle returns the old word on B.
module vip_osd_ram #(
   parameter int ADDR_BITS = 9,
   parameter int DATA_BITS = 32
) (
   input  logic                 pclk,
   input  logic                 rst_n,
   input  logic                 a_wen,
   input  logic                 a_ren,
   input  logic [ADDR_BITS-1:0] a_addr,
   input  logic [DATA_BITS-1:0] a_wdata,
   output logic [DATA_BITS-1:0] a_rdata,
   input  logic [ADDR_BITS-1:0] b_addr,
   output logic [DATA_BITS-1:0] b_rdata
);

   logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

   always_ff @(posedge pclk) begin
      if (a_wen) mem[a_addr] <= a_wdata;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         if (a_ren && !a_wen) a_rdata <= mem[a_addr];
         b_rdata <= mem[b_addr];
      end
   end

endmodule

// File: rtl/vip_osd.sv
// Streaming 1bpp bitmap overlay with alpha blend, fixed 3-cycle latency.
// Build option OSD_BG_TRANSPARENT_EN: clear bitmap bits pass the input pixel.
module vip_osd
   import vip_osd_pkg::*;
#(
   parameter int BITS              = 8,
   parameter int WIDTH             = 1920,
   parameter int HEIGHT            = 1080,
   parameter int OSD_RAM_ADDR_BITS = 9,
   parameter int OSD_RAM_DATA_BITS = 32
) (
   input  logic                         pclk,
   input  logic                         rst_n,
   input  logic [11:0]                  osd_x,
   input  logic [11:0]                  osd_w,
   input  logic [10:0]                  osd_y,
   input  logic [10:0]                  osd_h,
   input  logic [BITS-1:0]              fg_color_r,
   input  logic [BITS-1:0]              fg_color_g,
   input  logic [BITS-1:0]              fg_color_b,
   input  logic [BITS-1:0]              bg_color_r,
   input  logic [BITS-1:0]              bg_color_g,
   input  logic [BITS-1:0]              bg_color_b,
   input  logic [ALPHA_BITS-1:0]        alpha,
   input  logic                         in_href,
   input  logic                         in_vsync,
   input  logic [BITS-1:0]              in_data_r,
   input  logic [BITS-1:0]              in_data_g,
   input  logic [BITS-1:0]              in_data_b,
   output logic                         out_href,
   output logic                         out_vsync,
   output logic [BITS-1:0]              out_data_r,
   output logic [BITS-1:0]              out_data_g,
   output logic [BITS-1:0]              out_data_b,
   input  logic                         osd_ram_wen,
   input  logic                         osd_ram_ren,
   input  logic [OSD_RAM_ADDR_BITS-1:0] osd_ram_addr,
   input  logic [OSD_RAM_DATA_BITS-1:0] osd_ram_wdata,
   output logic [OSD_RAM_DATA_BITS-1:0] osd_ram_rdata
);

   localparam int XW  = $clog2(WIDTH + 1);
   localparam int YW  = $clog2(HEIGHT + 1);
   localparam int BIW = $clog2(OSD_RAM_DATA_BITS);
   localparam int PW  = OSD_RAM_ADDR_BITS + BIW;
   localparam int MW  = BITS + 9;

`ifdef OSD_BG_TRANSPARENT_EN
   localparam bit BG_BLEND = 1'b0;
`else
   localparam bit BG_BLEND = 1'b1;
`endif

   logic [11:0]           cfg_x, cfg_w;
   logic [10:0]           cfg_y, cfg_h;
   logic [BITS-1:0]       cfg_fg [3];
   logic [BITS-1:0]       cfg_bg [3];
   logic [ALPHA_BITS-1:0] cfg_alpha;

   logic [XW-1:0]  x_cnt;
   logic [YW-1:0]  y_cnt;
   logic [PW-1:0]  p_cnt;
   logic           href_d;
   logic           in_win;
   logic [BITS-1:0] in_d [3];

   logic                         s1_win, s1_href, s1_vsync;
   logic [OSD_RAM_ADDR_BITS-1:0] s1_addr;
   logic [BIW-1:0]               s1_bit;
   logic [BITS-1:0]              s1_d [3];
   logic                         s2_win, s2_href, s2_vsync;
   logic [BIW-1:0]               s2_bit;
   logic [BITS-1:0]              s2_d [3];
   logic [OSD_RAM_DATA_BITS-1:0] vid_word;
   logic                         pix_bit;
   logic [MW-1:0]                mix [3];
   logic [BITS-1:0]              col [3];
   logic [BITS-1:0]              blend [3];
   logic [BITS-1:0]              out_d [3];
   logic [8:0]                   inv_alpha;

   assign in_d[0] = in_data_r;
   assign in_d[1] = in_data_g;
   assign in_d[2] = in_data_b;

   assign in_win = in_href
                && (13'(x_cnt) >= {1'b0, cfg_x}) && (13'(x_cnt) < ({1'b0, cfg_x} + {1'b0, cfg_w}))
                && (12'(y_cnt) >= {1'b0, cfg_y}) && (12'(y_cnt) < ({1'b0, cfg_y} + {1'b0, cfg_h}));

   // Counters and per-frame config snapshot taken while vsync is high.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt     <= '0;
         y_cnt     <= '0;
         p_cnt     <= '0;
         href_d    <= 1'b0;
         cfg_x     <= '0;
         cfg_w     <= '0;
         cfg_y     <= '0;
         cfg_h     <= '0;
         cfg_alpha <= '0;
         for (int i = 0; i < 3; i++) begin
            cfg_fg[i] <= '0;
            cfg_bg[i] <= '0;
         end
      end else begin
         href_d <= in_href;
         x_cnt  <= in_href ? x_cnt + 1'b1 : '0;
         if (in_vsync)                y_cnt <= '0;
         else if (href_d && !in_href) y_cnt <= y_cnt + 1'b1;
         if (in_vsync)                p_cnt <= '0;
         else if (in_win)             p_cnt <= p_cnt + 1'b1;
         if (in_vsync) begin
            cfg_x     <= osd_x;
            cfg_w     <= osd_w;
            cfg_y     <= osd_y;
            cfg_h     <= osd_h;
            cfg_alpha <= alpha;
            cfg_fg[0] <= fg_color_r;
            cfg_fg[1] <= fg_color_g;
            cfg_fg[2] <= fg_color_b;
            cfg_bg[0] <= bg_color_r;
            cfg_bg[1] <= bg_color_g;
            cfg_bg[2] <= bg_color_b;
         end
      end
   end

   vip_osd_ram #(
      .ADDR_BITS (OSD_RAM_ADDR_BITS),
      .DATA_BITS (OSD_RAM_DATA_BITS)
   ) u_ram (
      .pclk    (pclk),
      .rst_n   (rst_n),
      .a_wen   (osd_ram_wen),
      .a_ren   (osd_ram_ren),
      .a_addr  (osd_ram_addr),
      .a_wdata (osd_ram_wdata),
      .a_rdata (osd_ram_rdata),
      .b_addr  (s1_addr),
      .b_rdata (vid_word)
   );

   // Stage 1 forms the word address; the RAM output register is stage 2.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         s1_win   <= 1'b0;
         s1_href  <= 1'b0;
         s1_vsync <= 1'b0;
         s1_addr  <= '0;
         s1_bit   <= '0;
         s2_win   <= 1'b0;
         s2_href  <= 1'b0;
         s2_vsync <= 1'b0;
         s2_bit   <= '0;
         out_href  <= 1'b0;
         out_vsync <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            s1_d[i]  <= '0;
            s2_d[i]  <= '0;
            out_d[i] <= '0;
         end
      end else begin
         s1_win   <= in_win;
         s1_href  <= in_href;
         s1_vsync <= in_vsync;
         s1_addr  <= p_cnt[PW-1:BIW];
         s1_bit   <= BIW'(bit_sel(32'(p_cnt[BIW-1:0]), OSD_RAM_DATA_BITS));
         s2_win   <= s1_win;
         s2_href  <= s1_href;
         s2_vsync <= s1_vsync;
         s2_bit   <= s1_bit;
         out_href  <= s2_href;
         out_vsync <= s2_vsync;
         for (int i = 0; i < 3; i++) begin
            s1_d[i]  <= in_d[i];
            s2_d[i]  <= s1_d[i];
            out_d[i] <= blend[i];
         end
      end
   end

   assign pix_bit   = vid_word[s2_bit];
   assign inv_alpha = 9'd256 - {1'b0, cfg_alpha};

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         col[i]   = pix_bit ? cfg_fg[i] : cfg_bg[i];
         mix[i]   = MW'(col[i]) * MW'(cfg_alpha) + MW'(s2_d[i]) * MW'(inv_alpha);
         blend[i] = s2_d[i];
         if (s2_win && (pix_bit || BG_BLEND)) blend[i] = mix[i][BLEND_SHIFT +: BITS];
      end
   end

   assign out_data_r = out_d[0];
   assign out_data_g = out_d[1];
   assign out_data_b = out_d[2];

endmodule

// File: tb/tb_vip_osd.sv
// Randomized self-checking bench for vip_osd against a frame-level reference model.
`timescale 1ns/1ps
module tb_vip_osd;

   localparam int BITS    = 8;
   localparam int AW      = 9;
   localparam int DW      = 32;
   localparam int DEPTH   = 1 << AW;
   localparam int LINE_PX = 200;

   logic            pclk = 1'b0;
   logic            rst_n = 1'b1;
   logic [11:0]     osd_x = '0, osd_w = '0;
   logic [10:0]     osd_y = '0, osd_h = '0;
   logic [BITS-1:0] fg_color_r = '0, fg_color_g = '0, fg_color_b = '0;
   logic [BITS-1:0] bg_color_r = '0, bg_color_g = '0, bg_color_b = '0;
   logic [7:0]      alpha = '0;
   logic            in_href = 1'b0, in_vsync = 1'b0;
   logic [BITS-1:0] in_data_r = '0, in_data_g = '0, in_data_b = '0;
   logic            out_href, out_vsync;
   logic [BITS-1:0] out_data_r, out_data_g, out_data_b;
   logic            osd_ram_wen = 1'b0, osd_ram_ren = 1'b0;
   logic [AW-1:0]   osd_ram_addr = '0;
   logic [DW-1:0]   osd_ram_wdata = '0;
   logic [DW-1:0]   osd_ram_rdata;

   always #5 pclk = ~pclk;

   vip_osd dut (
      .pclk(pclk), .rst_n(rst_n),
      .osd_x(osd_x), .osd_w(osd_w), .osd_y(osd_y), .osd_h(osd_h),
      .fg_color_r(fg_color_r), .fg_color_g(fg_color_g), .fg_color_b(fg_color_b),
      .bg_color_r(bg_color_r), .bg_color_g(bg_color_g), .bg_color_b(bg_color_b),
      .alpha(alpha), .in_href(in_href), .in_vsync(in_vsync),
      .in_data_r(in_data_r), .in_data_g(in_data_g), .in_data_b(in_data_b),
      .out_href(out_href), .out_vsync(out_vsync),
      .out_data_r(out_data_r), .out_data_g(out_data_g), .out_data_b(out_data_b),
      .osd_ram_wen(osd_ram_wen), .osd_ram_ren(osd_ram_ren), .osd_ram_addr(osd_ram_addr),
      .osd_ram_wdata(osd_ram_wdata), .osd_ram_rdata(osd_ram_rdata)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: bitmap mirror, frame-latched settings, visible-pixel index.
   logic [DW-1:0] mem_m [DEPTH];
   int lx, ly, lw, lh, la;
   int lfg [3];
   int lbg [3];
   int mp;
   logic [25:0] exp_q [$];
   int          tag_q [$];
   bit fixed_in  = 1'b0;
   bit probe_en  = 1'b0;

   function automatic int mixv(input int c, input int pix, input int a);
      return (c * a + pix * (256 - a)) >> 8;
   endfunction

   task automatic model_clear();
      lx = 0; ly = 0; lw = 0; lh = 0; la = 0; mp = 0;
      for (int i = 0; i < 3; i++) begin lfg[i] = 0; lbg[i] = 0; end
      exp_q.delete();
      tag_q.delete();
   endtask

   task automatic probe(input int tag, input logic [23:0] got);
      logic [23:0] fg_px, bg_px;
      fg_px = 24'h588A74;
`ifdef OSD_BG_TRANSPARENT_EN
      bg_px = 24'h808080;
`else
      bg_px = 24'hA7A7A7;
`endif
      if (tag == 50 + 1000 * 2) chk("bit31_px50", 32'(got), 32'(fg_px));
      if (tag == 81 + 1000 * 2) chk("bit0_px81",  32'(got), 32'(fg_px));
      if (tag == 51 + 1000 * 2) chk("bg_px51",    32'(got), 32'(bg_px));
      if (tag == 49 + 1000 * 2) chk("left_px49",  32'(got), 32'h808080);
   endtask

   task automatic step(input bit hr, input bit vs, input int x, input int y,
                       input bit wen, input bit ren, input int addr, input logic [31:0] wdata);
      int pix [3];
      int o [3];
      bit win, bt;
      logic [31:0] w;
      logic [25:0] got, want;
      int tag;
      @(negedge pclk);
      if (exp_q.size() >= 3) begin
         want = exp_q.pop_front();
         tag  = tag_q.pop_front();
         got  = {out_href, out_vsync, out_data_r, out_data_g, out_data_b};
         chk("pix", 32'(got), 32'(want));
         if (probe_en) probe(tag, got[23:0]);
      end
      for (int i = 0; i < 3; i++) pix[i] = fixed_in ? 8'h80 : $urandom_range(0, 255);
      in_href = hr; in_vsync = vs;
      in_data_r = 8'(pix[0]); in_data_g = 8'(pix[1]); in_data_b = 8'(pix[2]);
      osd_ram_wen = wen; osd_ram_ren = ren; osd_ram_addr = AW'(addr); osd_ram_wdata = wdata;
      if (wen) mem_m[addr] = wdata;
      win = hr && x >= lx && x < lx + lw && y >= ly && y < ly + lh;
      w   = mem_m[(mp / 32) % DEPTH];
      bt  = w[31 - (mp % 32)];
      for (int i = 0; i < 3; i++) begin
         o[i] = pix[i];
`ifdef OSD_BG_TRANSPARENT_EN
         if (win && bt) o[i] = mixv(lfg[i], pix[i], la);
`else
         if (win) o[i] = mixv(bt ? lfg[i] : lbg[i], pix[i], la);
`endif
      end
      exp_q.push_back({hr, vs, 8'(o[0]), 8'(o[1]), 8'(o[2])});
      tag_q.push_back(hr ? x + 1000 * y : -1);
      if (vs) begin
         lx = osd_x; lw = osd_w; ly = osd_y; lh = osd_h; la = alpha;
         lfg[0] = fg_color_r; lfg[1] = fg_color_g; lfg[2] = fg_color_b;
         lbg[0] = bg_color_r; lbg[1] = bg_color_g; lbg[2] = bg_color_b;
         mp = 0;
      end else if (win) begin
         mp++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 32'h0);
   endtask

   task automatic frame(input int lines, input int abort_line, input bit wr_rand,
                        input int move_line, input int move_x);
      repeat (4) step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 0, 32'h0);
      idle(4);
      for (int y = 0; y < lines; y++) begin
         if (y == move_line) osd_x = 12'(move_x);
         for (int x = 0; x < LINE_PX; x++) begin
            if (y == abort_line && x == LINE_PX / 2) return;
            if (wr_rand) step(1'b1, 1'b0, x, y, 1'b1, 1'b0, (mp / 32) % DEPTH, $urandom());
            else         step(1'b1, 1'b0, x, y, 1'b0, 1'b0, 0, 32'h0);
         end
         idle(6);
      end
   endtask

   task automatic set_cfg(input int x, input int y, input int w, input int h, input int a,
                          input logic [23:0] fg, input logic [23:0] bg);
      osd_x = 12'(x); osd_y = 11'(y); osd_w = 12'(w); osd_h = 11'(h); alpha = 8'(a);
      {fg_color_r, fg_color_g, fg_color_b} = fg;
      {bg_color_r, bg_color_g, bg_color_b} = bg;
   endtask

   task automatic rand_cfg();
      set_cfg($urandom_range(0, 190), $urandom_range(0, 9), $urandom_range(0, 150),
              $urandom_range(0, 8), $urandom_range(0, 255), 24'($urandom()), 24'($urandom()));
   endtask

   initial begin
      model_clear();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out", {6'h0, out_href, out_vsync, out_data_r, out_data_g, out_data_b}, 32'h0);
      chk("rst_rdata", osd_ram_rdata, 32'h0);
      repeat (2) @(negedge pclk);
      rst_n = 1'b1;

      for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, a, $urandom());

      // Config port: write, read back, write-over-read priority.
      step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 5, 32'hDEADBEEF);
      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 5, 32'h0);
      @(posedge pclk); #1;
      chk("rdata_rd", osd_ram_rdata, 32'hDEADBEEF);
      step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 5, 32'h12345678);
      @(posedge pclk); #1;
      chk("rdata_hold", osd_ram_rdata, 32'hDEADBEEF);
      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 5, 32'h0);
      @(posedge pclk); #1;
      chk("rdata_new", osd_ram_rdata, 32'h12345678);

      // Passthrough with zero-width window.
      set_cfg(10, 1, 0, 5, 200, 24'h123456, 24'h654321);
      frame(6, -1, 1'b0, -1, 0);

      // Bit order: only the first and last bit of word 0 are set.
      for (int a = 0; a < 32; a++) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, a, 32'h0);
      step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 32'h80000001);
      set_cfg(50, 2, 128, 4, 8'h50, 24'h00A05A, 24'hFFFFFF);
      fixed_in = 1'b1;
      probe_en = 1'b1;
      frame(8, -1, 1'b0, -1, 0);
      probe_en = 1'b0;
      fixed_in = 1'b0;

      // Settings changed mid-frame take effect from the next frame only.
      for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, a, $urandom());
      set_cfg(20, 1, 60, 5, 128, 24'hFF0000, 24'h0000FF);
      frame(8, -1, 1'b0, 3, 100);
      frame(8, -1, 1'b0, -1, 0);

      // Random settings, including windows clipped by the line end,
      // and one frame rewriting the word under the video read each pixel.
      for (int f = 0; f < 4; f++) begin
         rand_cfg();
         frame(10, -1, f == 2, -1, 0);
      end

      // Reset mid-line, then recover after the next vsync.
      set_cfg(30, 1, 100, 6, 90, 24'h10E020, 24'h402010);
      frame(8, 3, 1'b0, -1, 0);
      @(negedge pclk);
      in_href = 1'b0; in_vsync = 1'b0;
      osd_ram_wen = 1'b0; osd_ram_ren = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out", {6'h0, out_href, out_vsync, out_data_r, out_data_g, out_data_b}, 32'h0);
      chk("rst_mid_rdata", osd_ram_rdata, 32'h0);
      repeat (3) @(negedge pclk);
      rst_n = 1'b1;
      model_clear();
      frame(8, -1, 1'b0, -1, 0);
      idle(4);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
